// File: rtl/ram_dp_bytewise_pkg.sv
// ---------------------------------------------------------------------------
// ram_dp_bytewise_pkg
// Shared definitions for the byte-writable dual-read RAM:
//   XLEN           - width of every address port
//   ram_state_e    - clear-sequencer states (RAM_ST_CLEAR / RAM_ST_READY)
//   addr_in_range  - true when no address bit at or above addr_w is set
// Build option consumed by ram_dp_bytewise: RAM_OUT_REG_EN (extra output
// register stage per read port).
// ---------------------------------------------------------------------------
package ram_dp_bytewise_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    RAM_ST_CLEAR = 1'b0,
    RAM_ST_READY = 1'b1
  } ram_state_e;

  function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                         input int unsigned     addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// ---------------------------------------------------------------------------
// ram_byte_merge
// Combinational byte-lane merge: lane b of merged_o comes from new_i when
// mask_i[b] is set, otherwise from old_i.
// Ports:
//   old_i    [WIDTH]  current word
//   new_i    [WIDTH]  incoming word, byte-lane aligned
//   mask_i   [NBYTE]  per-lane select
//   merged_o [WIDTH]  merged word
// ---------------------------------------------------------------------------
module ram_byte_merge #(
  parameter  int WIDTH = 32,
  localparam int NBYTE = WIDTH / 8
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] new_i,
  input  logic [NBYTE-1:0] mask_i,
  output logic [WIDTH-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < NBYTE; b++) begin
      if (mask_i[b]) merged_o[8*b +: 8] = new_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/ram_dp_bytewise.sv
// ---------------------------------------------------------------------------
// ram_dp_bytewise
// DEPTH x WIDTH on-chip RAM: one byte-masked write port, two registered read
// ports (port 2 gated by cs), write-first forwarding on same-address
// read-during-write, and a clear sequencer that zeroes one word per cycle
// after reset or on a clr request.
// Ports:
//   clk, rst (async, active-low)
//   cs, we, byte_we[NBYTE], waddr[XLEN], wdata[WIDTH]     write port
//   re1, raddr1[XLEN] -> rdata1[WIDTH], rvalid1             read port 1
//   re2, raddr2[XLEN] -> rdata2[WIDTH], rvalid2 (cs gated)  read port 2
//   clr -> busy                                             clear sweep
// Build option: RAM_OUT_REG_EN adds one output register per read port
// (read latency 2 instead of 1).
// ---------------------------------------------------------------------------
module ram_dp_bytewise
  import ram_dp_bytewise_pkg::*;
#(
  parameter  int DEPTH  = 512,
  parameter  int WIDTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NBYTE  = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             we,
  input  logic [NBYTE-1:0] byte_we,
  input  logic [XLEN-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re1,
  input  logic [XLEN-1:0]  raddr1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvalid1,
  input  logic             re2,
  input  logic [XLEN-1:0]  raddr2,
  output logic [WIDTH-1:0] rdata2,
  output logic             rvalid2,
  input  logic             clr,
  output logic             busy
);

  logic [WIDTH-1:0]  mem [DEPTH];

  ram_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              busy_q;
  logic              ready;

  logic [ADDR_W-1:0] wa, ra1, ra2;
  logic              wr_en, rd1_in, rd2_in, fwd1, fwd2;
  logic [WIDTH-1:0]  wr_merged, rd1_word, rd2_word;

  logic [WIDTH-1:0]  rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic              rvalid1_q, rvalid1_d, rvalid2_q, rvalid2_d;

  assign ready = (state_q == RAM_ST_READY);
  assign busy  = busy_q;

  // Clear sequencer: sweeps ptr over every word, then serves user traffic.
  // A clr seen while already clearing is ignored so a sweep never restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RAM_ST_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        RAM_ST_CLEAR: begin
          ptr_q <= ptr_q + ADDR_W'(1);
          if (ptr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RAM_ST_READY;
            busy_q  <= 1'b0;
          end
        end
        RAM_ST_READY: begin
          if (clr) begin
            state_q <= RAM_ST_CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= RAM_ST_CLEAR;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Write path: out-of-range addresses have upper bits set and are dropped.
  assign wa     = waddr[ADDR_W-1:0];
  assign ra1    = raddr1[ADDR_W-1:0];
  assign ra2    = raddr2[ADDR_W-1:0];
  assign wr_en  = ready && cs && we && addr_in_range(waddr, ADDR_W);
  assign rd1_in = addr_in_range(raddr1, ADDR_W);
  assign rd2_in = addr_in_range(raddr2, ADDR_W);

  // One merged word serves the array write and both forwarding paths: a
  // forward only fires when the read address equals waddr exactly.
  ram_byte_merge #(.WIDTH(WIDTH)) u_merge (
    .old_i   (mem[wa]),
    .new_i   (wdata),
    .mask_i  (byte_we),
    .merged_o(wr_merged)
  );

  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[ptr_q] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wr_merged;
    end
  end

  // Read stage: write-first forwarding, out-of-range reads return zero.
  // Port 2 shares cs with the write, so wr_en already implies its gate.
  assign fwd1     = wr_en && (raddr1 == waddr);
  assign fwd2     = wr_en && (raddr2 == waddr);
  assign rd1_word = !rd1_in ? '0 : (fwd1 ? wr_merged : mem[ra1]);
  assign rd2_word = !rd2_in ? '0 : (fwd2 ? wr_merged : mem[ra2]);

  always_comb begin
    rdata1_d  = rdata1_q;
    rvalid1_d = 1'b0;
    if (ready && re1) begin
      rdata1_d  = rd1_word;
      rvalid1_d = 1'b1;
    end
    rdata2_d  = rdata2_q;
    rvalid2_d = 1'b0;
    if (ready) begin
      if (!cs) begin
        rdata2_d = '0;
      end else if (re2) begin
        rdata2_d  = rd2_word;
        rvalid2_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1_q  <= '0;
      rvalid1_q <= 1'b0;
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata1_q  <= rdata1_d;
      rvalid1_q <= rvalid1_d;
      rdata2_q  <= rdata2_d;
      rvalid2_q <= rvalid2_d;
    end
  end

`ifdef RAM_OUT_REG_EN
  // Output stage: data, valid and the cs zeroing all move together.
  logic [WIDTH-1:0] rdata1_out_q, rdata2_out_q;
  logic             rvalid1_out_q, rvalid2_out_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata1_out_q  <= '0;
      rvalid1_out_q <= 1'b0;
      rdata2_out_q  <= '0;
      rvalid2_out_q <= 1'b0;
    end else begin
      rdata1_out_q  <= rdata1_q;
      rvalid1_out_q <= rvalid1_q;
      rdata2_out_q  <= rdata2_q;
      rvalid2_out_q <= rvalid2_q;
    end
  end

  assign rdata1  = rdata1_out_q;
  assign rvalid1 = rvalid1_out_q;
  assign rdata2  = rdata2_out_q;
  assign rvalid2 = rvalid2_out_q;
`else
  assign rdata1  = rdata1_q;
  assign rvalid1 = rvalid1_q;
  assign rdata2  = rdata2_q;
  assign rvalid2 = rvalid2_q;
`endif

endmodule

// File: doc/ram_dp_bytewise.md
Name: ram_dp_bytewise

Overview:
- Next-generation parametrised on-chip RAM, replacing the fixed 32-bit word store for the planned merged instruction/data memory.
- One write port with arbitrary byte-enable masks and two registered read ports; read port 2 is gated by chip select.
- Same-address read-during-write is forwarded write-first, so simultaneous access to one address is well defined.
- A post-reset clear sequencer zeroes the array one word per cycle, replacing a single-cycle reset of the whole array.

Parameters:
- DEPTH, 512: number of words; power of two, at least 2. ADDR_W = clog2(DEPTH), derived.
- WIDTH, 32: word width in bits; multiple of 8, at most XLEN. NBYTE = WIDTH/8, derived.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- cs  in  1  chip select; gates writes and read port 2
- we  in  1  write request
- byte_we  in  NBYTE  byte write mask; any pattern is legal
- waddr  in  XLEN  write word index
- wdata  in  WIDTH  write data, byte-lane aligned
- re1  in  1  read request, port 1
- raddr1  in  XLEN  read word index, port 1
- rdata1  out  WIDTH  read data, port 1
- rvalid1  out  1  port 1 data valid pulse
- re2  in  1  read request, port 2
- raddr2  in  XLEN  read word index, port 2
- rdata2  out  WIDTH  read data, port 2
- rvalid2  out  1  port 2 data valid pulse
- clr  in  1  request a re-clear sweep
- busy  out  1  clear sweep in progress

Behaviour:
- Reset (rst=0): rdata1=rdata2=0, rvalid1=rvalid2=0, busy=1, FSM=CLEAR, clear pointer=0. Array contents are not reset directly.
- FSM CLEAR: writes 0 to ram[ptr] each cycle and increments ptr. In the cycle ptr==DEPTH-1 it moves to READY; busy falls on the following edge, DEPTH cycles after reset release.
- FSM READY: normal operation. clr=1 in READY moves to CLEAR with ptr=0 and busy=1 from the next edge. clr while already in CLEAR is ignored (no restart).
- While busy: user writes are dropped; reads are not accepted (rvalid=0, rdata holds).
- Address range: an address is in range when its bits above ADDR_W-1 are zero.
  - Out-of-range write: dropped.
  - Out-of-range read: accepted, returns 0, rvalid pulses.
- Write (READY, we&cs, waddr in range): byte lane b of ram[waddr] takes wdata lane b where byte_we[b]=1. Unmasked lanes are unchanged. byte_we=0 is a no-op.
- Read latency is 1 cycle.
  - Port 1: re1=1 in READY registers data and drives rvalid1=1 for one cycle. re1=0 holds rdata1 and drives rvalid1=0.
  - Port 2: same, with cs as a gate. cs=0 drives rdata2=0 and rvalid2=0 at the next edge, regardless of re2.
- Read-during-write, same address, same cycle: read data = merge(old word, wdata, byte_we), i.e. write-first. Applies independently on each port. Port 1 forwards only when the write itself is enabled (cs=1).
- Two reads of the same address in one cycle: both return the same word.
- Reset asserted mid-operation: any in-flight read is discarded and rvalid=0. The array is re-cleared by the CLEAR sweep.

Optional Feature:
- Macro: RAM_OUT_REG_EN.
- Defined: adds one output register stage per port. Read latency is 2 cycles; rvalid, forwarding result and the cs=0 zeroing all move with the data. Output registers reset to 0.
- Undefined: latency 1 exactly as above. No extra flops.

Decomposition:
- Shared defines file (existing): XLEN, ZEROWORD, RAM_RST_ENABLE, RAM_READ_ENABLE, RAM_WRITE_ENABLE, RST_EDGE; RST_EDGE is set to negedge for this block.
- Add to the shared defines: RAM_ST_CLEAR and RAM_ST_READY state encodings, and the RAM_OUT_REG_EN option.
- Sub-module: ram_byte_merge (combinational; inputs old word, new word, mask; output merged word). Used for the array write and for both forwarding paths.

Test Plan (DEPTH=512, WIDTH=32):
- Release reset -> busy=1 for exactly 512 cycles then 0; a read of addr 511 returns 0x00000000 with rvalid1=1 one cycle after re1.
- Write 0xAABBCCDD to addr 5 with mask 1111, then mask 0101 with wdata 0x11223344 -> read of addr 5 returns 0xAA22CC44.
- Write addr 7 with 0xDEADBEEF, mask 1100, and read ports 1 and 2 of addr 7 in the same cycle (old word 0) -> both return 0xDEAD0000.
- cs=0 with re2=1 on addr 5 -> rdata2=0, rvalid2=0; re1 on addr 5 in the same cycle -> rdata1=0xAA22CC44, rvalid1=1.
- raddr1=600 -> rdata1=0, rvalid1=1; write to addr 600 -> array unchanged (addr 88 = 600 mod 512 still reads its prior value).
- Pulse clr in READY, or assert rst mid-read -> busy=1 for 512 cycles, rvalid=0 throughout, and all words read 0 afterwards. With RAM_OUT_REG_EN defined, rerun the cases above and check latency is 2.
